// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline hazard controller.
//   hz_state_t : controller state encoding (RUN, MEM_WAIT, FLUSH, FAULT)
//   REG_ZERO   : index of the hard-wired zero register, which never creates a hazard
//   hz_ctrl_t  : bundle of the pipeline-register enable/bubble controls
package mips_pipe_pkg;

  typedef logic [1:0] hz_state_t;

  localparam hz_state_t StRun     = 2'd0;
  localparam hz_state_t StMemWait = 2'd1;
  localparam hz_state_t StFlush   = 2'd2;
  localparam hz_state_t StFault   = 2'd3;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_bubble;
  } hz_ctrl_t;

  // Free-running pipeline.
  localparam hz_ctrl_t CtrlRun = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, exmem_en: 1'b1, memwb_bubble: 1'b0};
  // Whole pipeline frozen; ID/EX holds (no bubble), MEM/WB receives a bubble.
  localparam hz_ctrl_t CtrlHold = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exmem_en: 1'b0, memwb_bubble: 1'b1};
  // Wrong-path squash: PC takes the target, IF/ID loads a NOP, ID/EX gets a bubble.
  localparam hz_ctrl_t CtrlFlush = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                     idex_bubble: 1'b1, exmem_en: 1'b1, memwb_bubble: 1'b0};
  // Load-use: hold PC and IF/ID for one cycle, bubble into ID/EX.
  localparam hz_ctrl_t CtrlLoadUse = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b1, exmem_en: 1'b1, memwb_bubble: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side (drives stage status, receives enable/bubble controls)
//   slave  : hazard controller side
// Signals: ID source regs and use flags, EX load/destination, MEM access/ready, redirect,
// enable/flush/bubble controls, sticky memory fault and three 32-bit perf counters.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             idex_MemRead;
  logic [REG_W-1:0] idex_regDst;
  logic             exmem_MemRead;
  logic             exmem_MemWrite;
  logic             mem_ready;
  logic             redirect;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_fault;
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
  logic [31:0]      wait_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, idex_MemRead, idex_regDst,
           exmem_MemRead, exmem_MemWrite, mem_ready, redirect,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, mem_fault,
           stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, idex_MemRead, idex_regDst,
           exmem_MemRead, exmem_MemWrite, mem_ready, redirect,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, mem_fault,
           stall_cnt, flush_cnt, wait_cnt
  );

endinterface

// File: rtl/hz_sat_counter.sv
// Saturating event counter, updated on the falling clock edge like the pipeline registers.
// Ports: clock, clear (synchronous, wins over en), en (count this cycle), count (value).
module hz_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(negedge clock) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls, data-memory wait
// freezes with timeout fault, and wrong-path flushes after a taken branch/jump.
// Ports: clock (state updates on falling edge), reset (synchronous, active-high),
//        bus (pipe_hazard_ctrl_if.slave: stage status in, enable/bubble controls out).
// Parameters: FLUSH_CYCLES (1..3 bubble cycles per redirect), MEM_TIMEOUT (stall cycles
//             before fault, 0 = never), REG_W (register index width).
// Optional feature: define HAZARD_PERF_EN to build the stall/flush/wait perf counters;
// otherwise the counter outputs are tied to zero.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned REG_W        = 5
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLimit   = WaitW'(MEM_TIMEOUT);
  localparam logic [1:0]       FlushReload = 2'(FLUSH_CYCLES - 1);
  localparam logic [REG_W-1:0] RegZero     = REG_W'(REG_ZERO);

  hz_state_t        state_q, state_d;
  logic [1:0]       flush_timer_q, flush_timer_d;
  logic [WaitW-1:0] wait_timer_q, wait_timer_d;
  logic [WaitW-1:0] wait_inc;
  logic             redir_pend_q, redir_pend_d;

  hz_ctrl_t ctrl;
  hz_ctrl_t ctrl_out;
  logic     mem_wait;
  logic     load_use;
  logic     redir;
  logic     lu_stall;
  logic     wait_stall;

  assign mem_wait = (bus.exmem_MemRead | bus.exmem_MemWrite) & ~bus.mem_ready;
  assign load_use = bus.idex_MemRead & (bus.idex_regDst != RegZero) &
                    ((bus.id_uses_rs & (bus.id_rs == bus.idex_regDst)) |
                     (bus.id_uses_rt & (bus.id_rt == bus.idex_regDst)));
  // A redirect that arrived during a memory wait is replayed once the wait ends.
  assign redir    = bus.redirect | redir_pend_q;
  assign wait_inc = (wait_timer_q == '1) ? wait_timer_q : wait_timer_q + WaitW'(1);

  always_comb begin
    ctrl          = CtrlRun;
    state_d       = state_q;
    flush_timer_d = flush_timer_q;
    wait_timer_d  = wait_timer_q;
    redir_pend_d  = redir_pend_q;
    lu_stall      = 1'b0;
    wait_stall    = 1'b0;

    if (state_q == StFault) begin
      ctrl = CtrlHold;
    end else if (mem_wait) begin
      // wait_timer counts every stalled cycle, including the one that enters the wait.
      // flush_timer is left alone so an interrupted flush resumes after the wait.
      ctrl         = CtrlHold;
      wait_stall   = 1'b1;
      wait_timer_d = wait_inc;
      redir_pend_d = redir_pend_q | bus.redirect;
      if ((MEM_TIMEOUT != 0) && (wait_inc >= WaitLimit)) begin
        state_d = StFault;
      end else begin
        state_d = StMemWait;
      end
    end else begin
      wait_timer_d = '0;
      redir_pend_d = 1'b0;
      if (redir) begin
        ctrl          = CtrlFlush;
        flush_timer_d = FlushReload;
        state_d       = (FlushReload != 2'd0) ? StFlush : StRun;
      end else if (flush_timer_q != 2'd0) begin
        ctrl          = CtrlFlush;
        flush_timer_d = flush_timer_q - 2'd1;
        state_d       = (flush_timer_q != 2'd1) ? StFlush : StRun;
      end else begin
        // Also reached on the release cycle of a wait, which is effectively RUN; the load
        // in EX was held through the wait and must still be checked against ID.
        state_d = StRun;
        if (load_use) begin
          ctrl     = CtrlLoadUse;
          lu_stall = 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state_q       <= StRun;
      flush_timer_q <= 2'd0;
      wait_timer_q  <= '0;
      redir_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_timer_q <= flush_timer_d;
      wait_timer_q  <= wait_timer_d;
      redir_pend_q  <= redir_pend_d;
    end
  end

  // During reset the pipeline runs freely with no bubbles.
  assign ctrl_out = reset ? CtrlRun : ctrl;

  assign bus.pc_en        = ctrl_out.pc_en;
  assign bus.ifid_en      = ctrl_out.ifid_en;
  assign bus.ifid_flush   = ctrl_out.ifid_flush;
  assign bus.idex_bubble  = ctrl_out.idex_bubble;
  assign bus.exmem_en     = ctrl_out.exmem_en;
  assign bus.memwb_bubble = ctrl_out.memwb_bubble;
  assign bus.mem_fault    = ~reset & (state_q == StFault);

`ifdef HAZARD_PERF_EN
  hz_sat_counter #(.W(32)) u_stall_cnt (
    .clock (clock),
    .clear (reset),
    .en    (lu_stall),
    .count (bus.stall_cnt)
  );

  hz_sat_counter #(.W(32)) u_flush_cnt (
    .clock (clock),
    .clear (reset),
    .en    (ctrl.ifid_flush),
    .count (bus.flush_cnt)
  );

  hz_sat_counter #(.W(32)) u_wait_cnt (
    .clock (clock),
    .clear (reset),
    .en    (wait_stall),
    .count (bus.wait_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf   = lu_stall ^ wait_stall;
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
  assign bus.wait_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4). Stimulus is driven
// just after each falling edge and the expected controls are queued; a monitor pops and
// compares on the following rising edge.
module tb_pipe_hazard_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, mem_fault}
  localparam logic [6:0] EIdle = 7'b1100100;
  localparam logic [6:0] ELu   = 7'b0001100;
  localparam logic [6:0] EHold = 7'b0000010;
  localparam logic [6:0] EFlsh = 7'b1111100;
  localparam logic [6:0] EFlt  = 7'b0000011;

`ifdef HAZARD_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  ctrl;
    logic        chk_cnt;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [31:0] waitc;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  exp_t  exp_q[$];
  string name_q[$];

  pipe_hazard_ctrl_if #(.REG_W(5)) bus ();

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .REG_W        (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] ev(input int n);
    return PerfOn ? 32'(n) : 32'd0;
  endfunction

  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic imr,
                      input logic [4:0] dst, input logic mr, input logic mw,
                      input logic rdy, input logic rd, input logic [6:0] e, input string nm);
    exp_t x;
    @(negedge clock);
    #1;
    reset              = rst;
    bus.id_rs          = rs;
    bus.id_rt          = rt;
    bus.id_uses_rs     = urs;
    bus.id_uses_rt     = urt;
    bus.idex_MemRead   = imr;
    bus.idex_regDst    = dst;
    bus.exmem_MemRead  = mr;
    bus.exmem_MemWrite = mw;
    bus.mem_ready      = rdy;
    bus.redirect       = rd;
    x = '0;
    x.ctrl = e;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [6:0] e, input string nm);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, e, nm);
  endtask

  task automatic cnt_step(input logic [6:0] e, input int s, input int f, input int w,
                          input string nm);
    exp_t x;
    idle(e, nm);
    x = exp_q.pop_back();
    x.chk_cnt = 1'b1;
    x.stall   = ev(s);
    x.flush   = ev(f);
    x.waitc   = ev(w);
    exp_q.push_back(x);
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      exp_t       e;
      string      nm;
      logic [6:0] act;
      @(posedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.exmem_en,
               bus.memwb_bubble, bus.mem_fault};
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL %s ctrl actual=%b required=%b", nm, act, e.ctrl);
        end
        if (e.chk_cnt) begin
          checks++;
          if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== {e.stall, e.flush, e.waitc}) begin
            errors++;
            $display("FAIL %s counters actual=%0d/%0d/%0d required=%0d/%0d/%0d", nm,
                     bus.stall_cnt, bus.flush_cnt, bus.wait_cnt, e.stall, e.flush, e.waitc);
          end
        end
      end
    end
  end

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    bus.id_rs          = '0;
    bus.id_rt          = '0;
    bus.id_uses_rs     = 1'b0;
    bus.id_uses_rt     = 1'b0;
    bus.idex_MemRead   = 1'b0;
    bus.idex_regDst    = '0;
    bus.exmem_MemRead  = 1'b0;
    bus.exmem_MemWrite = 1'b0;
    bus.mem_ready      = 1'b1;
    bus.redirect       = 1'b0;

    // Reset: outputs idle even with hazard inputs present.
    step(1, 5'd2, 5'd0, 1, 0, 1, 5'd2, 0, 0, 1, 0, EIdle, "reset_loaduse");
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, EIdle, "reset_memwait");

    // Load-use on rs, one cycle only.
    step(0, 5'd2, 5'd0, 1, 0, 1, 5'd2, 0, 0, 1, 0, ELu, "lu_rs");
    idle(EIdle, "lu_release");

    // Memory wait: three not-ready cycles, release on the fourth.
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, EHold, "wait_1");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, EHold, "wait_2");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, EHold, "wait_3");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, 0, EIdle, "wait_release");
    cnt_step(EIdle, 1, 0, 3, "perf_after_lu_wait");

    // No-hazard patterns, then a load-use through rt.
    step(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 1, 0, EIdle, "lu_reg0");
    step(0, 5'd4, 5'd3, 1, 0, 1, 5'd3, 0, 0, 1, 0, EIdle, "lu_rt_unused");
    step(0, 5'd3, 5'd0, 1, 0, 0, 5'd3, 0, 0, 1, 0, EIdle, "lu_not_load");
    step(0, 5'd5, 5'd3, 1, 1, 1, 5'd3, 0, 0, 1, 0, ELu, "lu_rt");
    idle(EIdle, "lu_rt_release");

    // Redirect with two bubble cycles.
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, EFlsh, "redir_1");
    idle(EFlsh, "redir_2");
    idle(EIdle, "redir_done");
    // Redirect during FLUSH reloads the timer.
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, EFlsh, "reload_1");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, EFlsh, "reload_2");
    idle(EFlsh, "reload_3");
    idle(EIdle, "reload_done");
    // Redirect pulse during a wait is deferred until the wait ends.
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 1, EHold, "defer_wait_1");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, EHold, "defer_wait_2");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1, 0, EFlsh, "defer_flush_1");
    idle(EFlsh, "defer_flush_2");
    idle(EIdle, "defer_done");
    // Redirect outranks load-use.
    step(0, 5'd2, 5'd0, 1, 0, 1, 5'd2, 0, 0, 1, 1, EFlsh, "redir_over_lu");
    idle(EFlsh, "redir_over_lu_2");
    cnt_step(EIdle, 2, 9, 5, "perf_mid");

    // Timeout: four stalled cycles -> sticky fault until reset.
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, EHold, "to_1");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, EHold, "to_2");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, EHold, "to_3");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, EHold, "to_4");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, EFlt, "fault_ready");
    idle(EFlt, "fault_idle");
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1, EFlt, "fault_redirect");
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, EIdle, "fault_reset");
    idle(EIdle, "after_reset");
    step(0, 5'd7, 5'd0, 1, 0, 1, 5'd7, 0, 0, 1, 0, ELu, "after_reset_lu");
    cnt_step(EIdle, 1, 0, 0, "perf_after_reset");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
